// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-side memory stage.
//   word_t        16-bit data word carried on the processor data port
//   ADDR_*        memory-mapped I/O page addresses (0xF0..0xF3)
//   STAT_*        bit positions inside the STATUS register
package dmem_pkg;

    typedef logic [15:0] word_t;

    localparam logic [7:0] ADDR_OUT    = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'hF1;
    localparam logic [7:0] ADDR_IN     = 8'hF2;
    localparam logic [7:0] ADDR_CYCLES = 8'hF3;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 5;

endpackage

// File: rtl/data_mem_io_out_fifo.sv
// out_fifo: output word FIFO behind the OUT address.
//   clk, rst     clock, asynchronous active-high reset
//   push         write request, push_data is the word to store
//   pop          consumer request; ignored while empty
//   full, empty  occupancy flags
//   count        number of stored words (0..OUT_DEPTH)
//   head         word at the read pointer (meaningful only when !empty)
//   overflow     high in a cycle where a push is rejected (FIFO full, no pop)
// A pop frees a slot in the same cycle, so push+pop while full is accepted.
module out_fifo
    import dmem_pkg::*;
#(
    parameter int OUT_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  word_t                          push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(OUT_DEPTH+1)-1:0] count,
    output word_t                          head,
    output logic                           overflow
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    word_t         mem [OUT_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign full     = (count == CW'(OUT_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign head     = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; contents past the read pointer are don't-care.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_mem_io.sv
// data_mem_io: data-side memory stage with RAM and a memory-mapped I/O page.
//   clk, rst        clock, asynchronous active-high reset
//   d_addr          word address; 0x00..RAM_WORDS-1 RAM, 0xF0..0xF3 I/O page
//   d_rd, d_wr      read / write strobes (write wins when both are high)
//   w_data          write data
//   r_data          registered read data, 1-cycle latency, held between reads
//   in_port         asynchronous external input, 2-flop synchronized
//   out_data        head of output FIFO
//   out_valid       FIFO non-empty
//   out_ready       consumer accept
// Handshake: a word transfers on a rising edge where out_valid && out_ready;
// out_data is stable while out_valid is high and out_ready is low.
// Build option DATA_MEM_CYCLE_CNT_EN adds a 16-bit cycle counter at 0xF3;
// without it 0xF3 is unmapped.
module data_mem_io
    import dmem_pkg::*;
#(
    parameter int OUT_DEPTH = 4,
    parameter int RAM_WORDS = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d_addr,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] w_data,
    output logic [15:0] r_data,
    input  logic [15:0] in_port,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int             RAM_AW    = $clog2(RAM_WORDS);
    localparam int             CW        = $clog2(OUT_DEPTH + 1);
    localparam logic [8:0]     RAM_LIMIT = 9'(RAM_WORDS);

    word_t          ram [RAM_WORDS];
    word_t          sync1;
    word_t          sync2;
    word_t          status;
    word_t          rd_value;
    logic           overflow_flag;
    logic           in_ram;
    logic           rd_en;
    logic           push;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_ovf;
    logic [CW-1:0]  fifo_count;

    assign in_ram = ({1'b0, d_addr} < RAM_LIMIT);
    // A simultaneous write suppresses the read entirely.
    assign rd_en  = d_rd && !d_wr;
    assign push   = d_wr && (d_addr == ADDR_OUT);

    out_fifo #(.OUT_DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (w_data),
        .pop       (out_valid && out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (out_data),
        .overflow  (fifo_ovf)
    );

    assign out_valid = !fifo_empty;

    always_comb begin
        status                                 = '0;
        status[STAT_FULL]                      = fifo_full;
        status[STAT_EMPTY]                     = fifo_empty;
        status[STAT_OVF]                       = overflow_flag;
        status[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);
    end

`ifdef DATA_MEM_CYCLE_CNT_EN
    word_t cycles;

    // A write to CYCLES overrides that edge's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycles <= '0;
        else if (d_wr && (d_addr == ADDR_CYCLES))
            cycles <= '0;
        else
            cycles <= cycles + 16'd1;
    end
`endif

    always_comb begin
        rd_value = '0;
        if (in_ram) begin
            rd_value = ram[d_addr[RAM_AW-1:0]];
        end else begin
            case (d_addr)
                ADDR_STATUS: rd_value = status;
                ADDR_IN:     rd_value = sync2;
`ifdef DATA_MEM_CYCLE_CNT_EN
                ADDR_CYCLES: rd_value = cycles;
`endif
                default:     rd_value = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (d_wr && in_ram)
            ram[d_addr[RAM_AW-1:0]] <= w_data;
    end

    // Overflow is sticky; a STATUS read returns it and then clears it,
    // unless a rejected push lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data        <= '0;
            sync1         <= '0;
            sync2         <= '0;
            overflow_flag <= 1'b0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            if (rd_en)
                r_data <= rd_value;
            if (fifo_ovf)
                overflow_flag <= 1'b1;
            else if (rd_en && (d_addr == ADDR_STATUS))
                overflow_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_io.sv
// tb_data_mem_io: randomized and directed bench for data_mem_io with a
// transaction-level reference model (array RAM, queue FIFO, sample history).
module tb_data_mem_io;

    localparam int OUT_DEPTH = 4;
    localparam int RAM_WORDS = 240;

    logic        clk;
    logic        rst;
    logic [7:0]  d_addr;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] w_data;
    logic [15:0] r_data;
    logic [15:0] in_port;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int vectors;
    int miscompares;

    data_mem_io #(.OUT_DEPTH(OUT_DEPTH), .RAM_WORDS(RAM_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_addr    (d_addr),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .w_data    (w_data),
        .r_data    (r_data),
        .in_port   (in_port),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_ram [256];
    bit          m_written [256];
    logic [15:0] m_q [$];
    bit          m_ovf;
    logic [15:0] m_r;
    logic [15:0] m_ra;
    bit          m_rk;
    logic [15:0] m_prev1;
    logic [15:0] m_prev2;
    int unsigned m_cyc;

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        int n;
        n = m_q.size();
        s = {7'd0, 5'(n), 1'b0, m_ovf, (n == 0), (n == OUT_DEPTH)};
        return s;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 0;
        m_r     = 16'h0;
        m_ra    = 16'h0;
        m_rk    = 1;
        m_prev1 = 16'h0;
        m_prev2 = 16'h0;
        m_cyc   = 0;
    endtask

    // One processor cycle: drive, predict, clock, update model, compare.
    task automatic step(input logic [7:0] a, input logic rd, input logic wr,
                        input logic [15:0] wd, input logic rdy);
        logic [15:0] rv;
        logic [15:0] ra;
        bit          rk;
        bit          pop;
        bit          push;
        bit          accepted;
        d_addr    = a;
        d_rd      = rd;
        d_wr      = wr;
        w_data    = wd;
        out_ready = rdy;
        rv = 16'h0;
        rk = 1;
        if (int'(a) < RAM_WORDS) begin
            rv = m_ram[a];
            rk = m_written[a];
        end else if (a == 8'hF1) begin
            rv = model_status();
        end else if (a == 8'hF2) begin
            rv = m_prev2;
        end
`ifdef DATA_MEM_CYCLE_CNT_EN
        else if (a == 8'hF3) begin
            rv = 16'(m_cyc);
        end
`endif
        ra = (a == 8'hF2) ? m_prev1 : rv;

        @(posedge clk);
        #1;

        if (rd && !wr) begin
            m_r  = rv;
            m_ra = ra;
            m_rk = rk;
        end
        pop  = (m_q.size() != 0) && rdy;
        push = wr && (a == 8'hF0);
        accepted = push && ((m_q.size() < OUT_DEPTH) || pop);
        if (pop)
            void'(m_q.pop_front());
        if (accepted)
            m_q.push_back(wd);
        if (push && !accepted)
            m_ovf = 1;
        else if (rd && !wr && (a == 8'hF1))
            m_ovf = 0;
        if (wr && (int'(a) < RAM_WORDS)) begin
            m_ram[a]     = wd;
            m_written[a] = 1;
        end
        if (wr && (a == 8'hF3))
            m_cyc = 0;
        else
            m_cyc = (m_cyc + 1) & 32'hFFFF;
        m_prev2 = m_prev1;
        m_prev1 = in_port;

        vectors++;
        if (out_valid !== (m_q.size() != 0)) begin
            miscompares++;
            $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, m_q.size() != 0);
        end
        if (m_q.size() != 0) begin
            vectors++;
            if (out_data !== m_q[0]) begin
                miscompares++;
                $display("FAIL out_data @%0t: got %h want %h", $time, out_data, m_q[0]);
            end
        end
        if (m_rk) begin
            vectors++;
            if ((r_data !== m_r) && (r_data !== m_ra)) begin
                miscompares++;
                $display("FAIL r_data @%0t addr %h: got %h want %h", $time, a, r_data, m_r);
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(8'h00, 1'b0, 1'b0, 16'h0, rdy);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (r_data !== 16'h0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got r_data=%h out_valid=%b want 0000/0", r_data, out_valid);
        end
        rst = 1'b0;
        model_reset();
        step(8'hF1, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'h0002) begin
            miscompares++;
            $display("FAIL reset_status: got %h want 0002", r_data);
        end
    endtask

    task automatic test_ram();
        step(8'h10, 1'b0, 1'b1, 16'h1234, 1'b0);
        step(8'h10, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL ram_round_trip: got %h want 1234", r_data);
        end
        step(8'h11, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if ($isunknown(out_valid)) begin
            miscompares++;
            $display("FAIL ram_unwritten_ctrl: out_valid=%b", out_valid);
        end
        // Top of RAM and a spread of random locations
        step(8'(RAM_WORDS - 1), 1'b0, 1'b1, 16'hCAFE, 1'b0);
        for (int i = 0; i < 12; i++)
            step(8'($urandom_range(0, RAM_WORDS - 1)), 1'b0, 1'b1, 16'($urandom), 1'b0);
        step(8'(RAM_WORDS - 1), 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(8'($urandom_range(0, RAM_WORDS - 1)), 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_fifo_fill();
        for (int i = 0; i < 5; i++)
            step(8'hF0, 1'b0, 1'b1, 16'(16'hA + i), 1'b0);
        step(8'hF1, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'h0045) begin
            miscompares++;
            $display("FAIL fill_status: got %h want 0045", r_data);
        end
        step(8'hF1, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'h0041) begin
            miscompares++;
            $display("FAIL ovf_cleared: got %h want 0041", r_data);
        end
        // OUT reads as zero
        step(8'hF0, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_data !== 16'(16'hA + i)) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, out_data, 16'hA + i);
            end
            idle(1'b1);
        end
        step(8'hF1, 1'b1, 1'b0, 16'h0, 1'b1);
        vectors++;
        if (r_data !== 16'h0002 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got status=%h valid=%b want 0002/0", r_data, out_valid);
        end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++)
            step(8'hF0, 1'b0, 1'b1, 16'(16'hA + i), 1'b0);
        step(8'hF0, 1'b0, 1'b1, 16'h000F, 1'b1);
        step(8'hF1, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'h0041) begin
            miscompares++;
            $display("FAIL push_pop_full_status: got %h want 0041", r_data);
        end
        for (int i = 0; i < 3; i++)
            idle(1'b1);
        vectors++;
        if (out_data !== 16'h000F || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL push_pop_full_last: got %h/%b want 000f/1", out_data, out_valid);
        end
        idle(1'b1);
        // Push into an empty FIFO while out_ready is already high
        step(8'hF0, 1'b0, 1'b1, 16'h0077, 1'b1);
        idle(1'b1);
    endtask

    task automatic test_rw_same();
        logic [15:0] held;
        step(8'h20, 1'b0, 1'b1, 16'h1111, 1'b0);
        step(8'h20, 1'b1, 1'b0, 16'h0, 1'b0);
        held = r_data;
        step(8'h20, 1'b1, 1'b1, 16'h5555, 1'b0);
        vectors++;
        if (r_data !== 16'h1111) begin
            miscompares++;
            $display("FAIL rw_same_hold: got %h want 1111 (was %h)", r_data, held);
        end
        step(8'h20, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'h5555) begin
            miscompares++;
            $display("FAIL rw_same_write: got %h want 5555", r_data);
        end
    endtask

    task automatic test_unmapped();
        step(8'hF7, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        step(8'hF7, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'h0) begin
            miscompares++;
            $display("FAIL unmapped_read: got %h want 0000", r_data);
        end
        step(8'hF3, 1'b1, 1'b0, 16'h0, 1'b0);
        step(8'hFF, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_sync();
        in_port = 16'h0000;
        repeat (3) idle(1'b0);
        in_port = 16'hBEEF;
        step(8'hF2, 1'b1, 1'b0, 16'h0, 1'b0);
        step(8'hF2, 1'b1, 1'b0, 16'h0, 1'b0);
        step(8'hF2, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL sync_settled: got %h want beef", r_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        int sel;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: a = 8'($urandom_range(0, 15));
                3, 4:    a = 8'hF0;
                5:       a = 8'hF1;
                6:       a = 8'hF2;
                7:       a = 8'hF3;
                8:       a = 8'(RAM_WORDS - 1);
                default: a = 8'hF9;
            endcase
            if ($urandom_range(0, 7) == 0)
                in_port = 16'($urandom);
            step(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom), 1'($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_reset_mid();
        step(8'h10, 1'b0, 1'b1, 16'h4321, 1'b0);
        step(8'h10, 1'b1, 1'b0, 16'h0, 1'b0);
        while (m_q.size() != 0)
            idle(1'b1);
        for (int i = 0; i < 3; i++)
            step(8'hF0, 1'b0, 1'b1, 16'(16'h100 + i), 1'b0);
        d_addr = 8'h10;
        d_rd   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || r_data !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got valid=%b r_data=%h want 0/0000", out_valid, r_data);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst  = 1'b0;
        d_rd = 1'b0;
        model_reset();
        step(8'hF3, 1'b1, 1'b0, 16'h0, 1'b0);
`ifdef DATA_MEM_CYCLE_CNT_EN
        vectors++;
        if (r_data > 16'd2) begin
            miscompares++;
            $display("FAIL cycles_after_reset: got %h want <= 2", r_data);
        end
`endif
        step(8'hF1, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

`ifdef DATA_MEM_CYCLE_CNT_EN
    task automatic test_cycles();
        step(8'hF3, 1'b0, 1'b1, 16'h0, 1'b0);
        repeat (5) idle(1'b0);
        step(8'hF3, 1'b1, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (r_data !== 16'd5) begin
            miscompares++;
            $display("FAIL cycles_count: got %0d want 5", r_data);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        d_addr      = 8'h0;
        d_rd        = 1'b0;
        d_wr        = 1'b0;
        w_data      = 16'h0;
        in_port     = 16'h0;
        out_ready   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            m_ram[i]     = 16'h0;
            m_written[i] = 0;
        end
        model_reset();

        test_reset();
        test_ram();
        test_fifo_fill();
        test_drain();
        test_push_pop_full();
        test_rw_same();
        test_unmapped();
        test_sync();
`ifdef DATA_MEM_CYCLE_CNT_EN
        test_cycles();
`endif
        test_random();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
